subtractor: RTL and testbench

Registered 8-bit unsigned subtractor computing out_v = g_vec − l_vec, where g_vec is the minuend and l_vec the subtrahend. It has a one-cycle pipeline register, a valid qualifier, and borrow/zero status flags. It serves as the difference stage in the datapath, feeding downstream comparators and accumulators. Underflow handling (wrap or clamp) is selected by parameter.

---
 rtl/subtractor.sv | 47 ++++
 tb/tb_subtractor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/subtractor.sv
// rtl/subtractor.sv - registered unsigned subtractor with valid qualifier, borrow/zero flags
module subtractor #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] g_vec,
  input  logic [WIDTH-1:0] l_vec,
  output logic [WIDTH-1:0] out_v,
  output logic             out_valid,
  output logic             borrow,
  output logic             zero
);

  logic [WIDTH:0]   diff;
  logic             diff_borrow;
  logic [WIDTH-1:0] result;

  // One extra bit so the borrow falls out of the MSB of the difference.
  always_comb begin
    diff        = {1'b0, g_vec} - {1'b0, l_vec};
    diff_borrow = diff[WIDTH];
    result      = diff[WIDTH-1:0];
    if (diff_borrow && (SATURATE != 0)) begin
      result = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v     <= '0;
      out_valid <= 1'b0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_v  <= result;
        borrow <= diff_borrow;
        zero   <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_subtractor.sv
// tb/tb_subtractor.sv - self-checking bench for subtractor, wrap and clamp instances side by side
module tb_subtractor;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] g_vec;
  logic [7:0] l_vec;

  logic [7:0] out_v_w, out_v_c;
  logic       out_valid_w, out_valid_c;
  logic       borrow_w, borrow_c;
  logic       zero_w, zero_c;

  logic [10:0] obs_w, obs_c;
  logic [10:0] ew, ec;
  int tot = 0;
  int bad = 0;

  assign obs_w = {out_v_w, out_valid_w, borrow_w, zero_w};
  assign obs_c = {out_v_c, out_valid_c, borrow_c, zero_c};

  subtractor #(.WIDTH(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .g_vec(g_vec), .l_vec(l_vec),
    .out_v(out_v_w), .out_valid(out_valid_w), .borrow(borrow_w), .zero(zero_w)
  );

  subtractor #(.WIDTH(8), .SATURATE(1)) u_clamp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .g_vec(g_vec), .l_vec(l_vec),
    .out_v(out_v_c), .out_valid(out_valid_c), .borrow(borrow_c), .zero(zero_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {out_v, out_valid, borrow, zero} after one edge, from signed integer arithmetic.
  function automatic logic [10:0] expect_out(input int g, input int l, input bit sat,
                                             input logic [10:0] prev, input bit vld);
    int d;
    int r;
    bit b;
    if (!vld) return {prev[10:3], 1'b0, prev[1:0]};
    d = g - l;
    b = (d < 0);
    if (b) r = sat ? 0 : d + 256;
    else   r = d;
    return {r[7:0], 1'b1, b, (r == 0)};
  endfunction

  task automatic drive(input bit v, input logic [7:0] g, input logic [7:0] l);
    in_valid = v;
    g_vec    = g;
    l_vec    = l;
    @(posedge clk);
    #1;
    ew = expect_out(int'(g), int'(l), 1'b0, ew, v);
    ec = expect_out(int'(g), int'(l), 1'b1, ec, v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom));
      ew = '0;
      ec = '0;
      tot++;
      if (obs_w !== 11'h000) begin bad++; $display("FAIL reset_hold_wrap got=%h want=000", obs_w); end
      tot++;
      if (obs_c !== 11'h000) begin bad++; $display("FAIL reset_hold_clamp got=%h want=000", obs_c); end
    end
    #2 rst = 1'b0;
    drive(1'b0, 8'd1, 8'd2);
    tot++;
    if (obs_w !== 11'h000) begin bad++; $display("FAIL reset_release got=%h want=000", obs_w); end
  endtask

  task automatic test_basic();
    drive(1'b1, 8'd10, 8'd5);
    tot++;
    if (obs_w !== {8'd5, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL basic_10_5 got=%h want=%h", obs_w, {8'd5, 3'b100}); end
    drive(1'b1, 8'd25, 8'd7);
    tot++;
    if (obs_w !== {8'd18, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL basic_25_7 got=%h want=%h", obs_w, {8'd18, 3'b100}); end
    tot++;
    if (obs_c !== {8'd18, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL basic_25_7_clamp got=%h want=%h", obs_c, {8'd18, 3'b100}); end
  endtask

  task automatic test_equal();
    drive(1'b1, 8'd42, 8'd42);
    tot++;
    if (obs_w !== {8'd0, 1'b1, 1'b0, 1'b1}) begin bad++; $display("FAIL equal_wrap got=%h want=%h", obs_w, {8'd0, 3'b101}); end
    tot++;
    if (obs_c !== {8'd0, 1'b1, 1'b0, 1'b1}) begin bad++; $display("FAIL equal_clamp got=%h want=%h", obs_c, {8'd0, 3'b101}); end
  endtask

  task automatic test_underflow();
    drive(1'b1, 8'd5, 8'd7);
    tot++;
    if (obs_w !== {8'd254, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL underflow_wrap got=%h want=%h", obs_w, {8'd254, 3'b110}); end
    tot++;
    if (obs_c !== {8'd0, 1'b1, 1'b1, 1'b1}) begin bad++; $display("FAIL underflow_clamp got=%h want=%h", obs_c, {8'd0, 3'b111}); end
  endtask

  task automatic test_hold();
    drive(1'b1, 8'd200, 8'd100);
    #2;
    g_vec = 8'd3;
    l_vec = 8'd9;
    #1;
    tot++;
    if (obs_w !== {8'd100, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL between_edges got=%h want=%h", obs_w, {8'd100, 3'b100}); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'($urandom), 8'($urandom));
      tot++;
      if (obs_w !== {8'd100, 1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL hold_%0d got=%h want=%h", i, obs_w, {8'd100, 3'b000}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] gs [4] = '{8'd255, 8'd0, 8'd0, 8'd128};
    logic [7:0] ls [4] = '{8'd0, 8'd0, 8'd255, 8'd127};
    logic [10:0] want_w [4] = '{{8'd255, 3'b100}, {8'd0, 3'b101}, {8'd1, 3'b110}, {8'd1, 3'b100}};
    logic [10:0] want_c [4] = '{{8'd255, 3'b100}, {8'd0, 3'b101}, {8'd0, 3'b111}, {8'd1, 3'b100}};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, gs[i], ls[i]);
      tot++;
      if (obs_w !== want_w[i]) begin bad++; $display("FAIL b2b_wrap_%0d got=%h want=%h", i, obs_w, want_w[i]); end
      tot++;
      if (obs_c !== want_c[i]) begin bad++; $display("FAIL b2b_clamp_%0d got=%h want=%h", i, obs_c, want_c[i]); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'd90, 8'd20);
    #3 rst = 1'b1;
    #1;
    tot++;
    if (obs_w !== 11'h000) begin bad++; $display("FAIL async_reset_wrap got=%h want=000", obs_w); end
    tot++;
    if (obs_c !== 11'h000) begin bad++; $display("FAIL async_reset_clamp got=%h want=000", obs_c); end
    drive(1'b1, 8'd50, 8'd10);
    ew = '0;
    ec = '0;
    #2 rst = 1'b0;
    drive(1'b0, 8'd50, 8'd10);
    tot++;
    if (obs_w !== 11'h000) begin bad++; $display("FAIL post_reset_idle got=%h want=000", obs_w); end
  endtask

  task automatic test_random();
    logic [7:0] g, l;
    for (int i = 0; i < 300; i++) begin
      g = 8'($urandom);
      l = ($urandom_range(0, 7) == 0) ? g : 8'($urandom);
      drive($urandom_range(0, 3) != 0, g, l);
      tot++;
      if (obs_w !== ew) begin bad++; $display("FAIL random_wrap_%0d got=%h want=%h", i, obs_w, ew); end
      tot++;
      if (obs_c !== ec) begin bad++; $display("FAIL random_clamp_%0d got=%h want=%h", i, obs_c, ec); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    g_vec    = '0;
    l_vec    = '0;
    ew       = '0;
    ec       = '0;
    test_reset();
    test_basic();
    test_equal();
    test_underflow();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
